fpaddsub_norm_shift: RTL
========================

// Module: fpaddsub_norm_shift
// PURPOSE
//  Post-add normalisation for the FP adder/subtractor datapath. Takes the raw 25-bit
//  mantissa sum (carry + 24 bits) and its exponent, left-shifts out leading zeros or
//  right-shifts 1 on carry-out, and adjusts the exponent. Two-stage pipeline with
//  valid/ready handshakes on input and output; sits between the mantissa adder and rounding.
// PARAMETERS
//  MW  24  mantissa width incl. hidden bit (sum input is MW+1 bits)
//  EW  8   exponent width; EMAX = 2**EW-1 (reserved inf/NaN code)
// PORTS
//  clk       in   1      clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  InValid   in   1      SumM/SumE valid
//  InReady   out  1      stage 1 can accept this cycle
//  SumM      in   MW+1   raw mantissa sum; bit MW = carry-out
//  SumE      in   EW     exponent of larger operand
//  OutValid  out  1      NormM/NormE/flags valid
//  OutReady  in   1      downstream accepts this cycle
//  NormM     out  MW     normalised mantissa (bit MW-1 = hidden bit, 0 if denormal)
//  NormE     out  EW     adjusted exponent
//  Sticky    out  1      bit shifted out on carry right-shift (SumM[0]), else 0
//  Zero      out  1      SumM was all zeros
//  Ovf       out  1      exponent overflow on carry (result forced to inf encoding)
//  Unf       out  1      left shift clamped by exponent; result is denormal
// BEHAVIOUR
//  Reset (async, rst_n=0): both stage valids 0, OutValid=0; NormM, NormE, Sticky, Zero,
//   Ovf, Unf = 0; InReady=1 after release. Reset mid-operation drops all in-flight data.
//  Handshake: transfer on InValid&InReady and on OutValid&OutReady. S2 advances when
//   !OutValid|OutReady; S1 advances when !S1valid|S2 advances; InReady = that S1 condition
//   (combinational from OutReady). Throughput 1/cycle; latency 2 cycles with OutReady=1.
//   Stall: registered data and flags held stable while OutValid&!OutReady.
//  Stage 1 (registered): classify and compute shift.
//   Zero: SumM==0 -> Zero=1, S=0.
//   Carry: SumM[MW]=1 -> M1=SumM[MW:1], Sticky=SumM[0], E1=SumE+1, S=0.
//    If SumE+1 >= EMAX: Ovf=1, final NormE=EMAX, NormM=0.
//   Else lz = leading zeros of SumM[MW-1:0] (0..MW-1).
//    SumE==0: S=0, NormE=0 (already denormal, no shift).
//    lz < SumE: S=lz, NormE=SumE-lz.
//    lz >= SumE (SumE>=1): S=SumE-1, NormE=0, Unf=1.
//   Coarse shift applied in S1: M1 = SumM[MW-1:0] << {S[4:2],2'b00}; zeros fill from LSB.
//  Stage 2 (registered): fine shift M1 << S[1:0] (0..3), zero fill; flags/NormE forwarded.
//  Exactly one of Zero/Ovf/Unf/normal per result; Zero => NormM=0, NormE=0.
//  Arithmetic: exponent math at EW+1 bits, no wrap; lz counter limited to MW-1.
// TESTING
//  1 SumM=25'h0800000,SumE=8'd127 -> 2 cycles later NormM=24'h800000,NormE=127,flags 0.
//  2 SumM=25'h1000001,SumE=8'd127 -> NormM=24'h800000,NormE=128,Sticky=1.
//  3 SumM=25'h0000010,SumE=8'd100 (lz=19) -> NormM=24'h800000,NormE=81.
//  4 SumM=25'h0000010,SumE=8'd5 -> S=4,NormM=24'h000100,NormE=0,Unf=1;
//    SumM=0 -> Zero=1,NormM=0,NormE=0; SumM=25'h1800000,SumE=254 -> Ovf=1,NormE=255,NormM=0.
//  5 Back-to-back 8 inputs, OutReady low 3 cycles mid-stream -> InReady drops only when
//    both stages full, outputs held stable, all 8 results in order, none lost/duplicated.
//  6 rst_n low while 2 results in flight -> OutValid=0 and outputs 0 same cycle;
//    after release first new input emerges with correct result 2 cycles later.

Source files
------------

// File: rtl/fpaddsub_norm_shift.sv
// Post-add normaliser for the FP adder/subtractor: classifies the raw sum, shifts out
// leading zeros (or right-shifts one on carry-out) and adjusts the exponent over two stages.
module fpaddsub_norm_shift #(
    parameter int MW = 24,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          InValid,
    output logic          InReady,
    input  logic [MW:0]   SumM,
    input  logic [EW-1:0] SumE,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [MW-1:0] NormM,
    output logic [EW-1:0] NormE,
    output logic          Sticky,
    output logic          Zero,
    output logic          Ovf,
    output logic          Unf
);

    localparam int SW = $clog2(MW);
    localparam logic [EW:0] EMAX = (EW+1)'((1 << EW) - 1);

    logic          s1_valid;
    logic [MW-1:0] s1_m;
    logic [1:0]    s1_fine;
    logic [EW-1:0] s1_e;
    logic          s1_sticky, s1_zero, s1_ovf, s1_unf;

    logic          s2_adv, s1_adv;
    logic [SW-1:0] lz;
    logic [EW:0]   e_ext, e_inc, e_dec, lz_ext;
    logic [SW-1:0] n_shift;
    logic [MW-1:0] n_src, n_m;
    logic [EW-1:0] n_e;
    logic          n_sticky, n_zero, n_ovf, n_unf;

    assign s2_adv  = !OutValid || OutReady;
    assign s1_adv  = !s1_valid || s2_adv;
    assign InReady = s1_adv;

    // Highest set bit wins; an all-zero field leaves lz at its MW-1 limit.
    always_comb begin
        lz = SW'(MW - 1);
        for (int i = 0; i < MW; i++) begin
            if (SumM[i]) lz = SW'(MW - 1 - i);
        end
    end

    assign e_ext  = {1'b0, SumE};
    assign e_inc  = e_ext + (EW+1)'(1);
    assign e_dec  = e_ext - (EW+1)'(1);
    assign lz_ext = (EW+1)'(lz);

    always_comb begin
        n_shift  = '0;
        n_src    = SumM[MW-1:0];
        n_e      = '0;
        n_sticky = 1'b0;
        n_zero   = 1'b0;
        n_ovf    = 1'b0;
        n_unf    = 1'b0;
        if (SumM == '0) begin
            n_zero = 1'b1;
            n_src  = '0;
        end else if (SumM[MW]) begin
            n_sticky = SumM[0];
            if (e_inc >= EMAX) begin
                n_ovf = 1'b1;
                n_e   = EMAX[EW-1:0];
                n_src = '0;
            end else begin
                n_src = SumM[MW:1];
                n_e   = e_inc[EW-1:0];
            end
        end else if (SumE == '0) begin
            n_e = '0;
        end else if (lz_ext < e_ext) begin
            n_shift = lz;
            n_e     = EW'(e_ext - lz_ext);
        end else begin
            // Exponent would go below 1: stop shifting and emit a denormal.
            n_shift = e_dec[SW-1:0];
            n_unf   = 1'b1;
        end
    end

    assign n_m = n_src << {n_shift[SW-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_m      <= '0;
            s1_fine   <= '0;
            s1_e      <= '0;
            s1_sticky <= 1'b0;
            s1_zero   <= 1'b0;
            s1_ovf    <= 1'b0;
            s1_unf    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= InValid;
            if (InValid) begin
                s1_m      <= n_m;
                s1_fine   <= n_shift[1:0];
                s1_e      <= n_e;
                s1_sticky <= n_sticky;
                s1_zero   <= n_zero;
                s1_ovf    <= n_ovf;
                s1_unf    <= n_unf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OutValid <= 1'b0;
            NormM    <= '0;
            NormE    <= '0;
            Sticky   <= 1'b0;
            Zero     <= 1'b0;
            Ovf      <= 1'b0;
            Unf      <= 1'b0;
        end else if (s2_adv) begin
            OutValid <= s1_valid;
            if (s1_valid) begin
                NormM  <= s1_m << s1_fine;
                NormE  <= s1_e;
                Sticky <= s1_sticky;
                Zero   <= s1_zero;
                Ovf    <= s1_ovf;
                Unf    <= s1_unf;
            end
        end
    end

endmodule
